// File: rtl/fetch.sv
// Instruction fetch: one outstanding imem request feeding a small decode FIFO.
// Define FETCH_PREFETCH_BUF_EN for a 2-entry buffer; default build uses 1 entry.
module fetch #(
    parameter logic [15:0] RESET_PC = 16'h3000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable_fetch,
    input  logic        br_taken,
    input  logic [15:0] taddr,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic        instr_valid,
    output logic [15:0] instr_dout,
    output logic [15:0] npc_out,
    input  logic        enable_decode,
    output logic [15:0] pc
);

`ifdef FETCH_PREFETCH_BUF_EN
    localparam int unsigned DEPTH = 2;
`else
    localparam int unsigned DEPTH = 1;
`endif
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_REQ  = 1'b1;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] npc;
    } entry_t;

    logic [0:0]       state, state_nx;
    logic [15:0]      pc_nx;
    logic             imem_req_nx;
    logic [15:0]      imem_addr_nx;
    logic             squash, squash_nx;
    logic [CNT_W-1:0] count, count_nx;
    logic [PTR_W-1:0] rd_ptr, rd_ptr_nx;
    logic [PTR_W-1:0] wr_ptr, wr_ptr_nx;
    logic             push_c;
    logic             pop_c;
    logic             space_c;
    entry_t           push_data_c;
    entry_t           head_c;
    entry_t           mem [DEPTH];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Head of the buffer; outputs read as zero whenever the buffer is empty
    assign head_c      = mem[rd_ptr];
    assign instr_valid = (count != '0);
    assign instr_dout  = instr_valid ? head_c.instr : 16'h0000;
    assign npc_out     = instr_valid ? head_c.npc   : 16'h0000;

    assign pop_c   = instr_valid && enable_decode && !br_taken;
    // A slot being freed this cycle may be reserved by the new request
    assign space_c = (count < CNT_W'(DEPTH)) || (instr_valid && enable_decode);

    // Request sequencing, redirect and squash handling
    always_comb begin
        state_nx     = state;
        pc_nx        = pc;
        imem_req_nx  = imem_req;
        imem_addr_nx = imem_addr;
        squash_nx    = squash;
        push_c       = 1'b0;
        push_data_c  = '{instr: imem_rdata, npc: imem_addr + 16'd1};
        case (state)
            S_IDLE: begin
                if (br_taken) begin
                    pc_nx = taddr;
                end else if (enable_fetch && space_c) begin
                    state_nx     = S_REQ;
                    imem_req_nx  = 1'b1;
                    imem_addr_nx = pc;
                end
            end
            S_REQ: begin
                if (imem_ack) begin
                    state_nx    = S_IDLE;
                    imem_req_nx = 1'b0;
                    squash_nx   = 1'b0;
                    if (br_taken) begin
                        pc_nx = taddr;
                    end else if (!squash) begin
                        push_c = 1'b1;
                        pc_nx  = imem_addr + 16'd1;
                    end
                end else if (br_taken) begin
                    squash_nx = 1'b1;
                    pc_nx     = taddr;
                end
            end
            default: begin
                state_nx    = S_IDLE;
                imem_req_nx = 1'b0;
            end
        endcase
    end

    // Buffer occupancy and pointers; a redirect empties the buffer outright
    always_comb begin
        count_nx  = count;
        rd_ptr_nx = rd_ptr;
        wr_ptr_nx = wr_ptr;
        if (br_taken) begin
            count_nx  = '0;
            rd_ptr_nx = '0;
            wr_ptr_nx = '0;
        end else begin
            if (push_c) wr_ptr_nx = ptr_inc(wr_ptr);
            if (pop_c)  rd_ptr_nx = ptr_inc(rd_ptr);
            if (push_c && !pop_c)      count_nx = count + CNT_W'(1);
            else if (pop_c && !push_c) count_nx = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= S_IDLE;
            pc        <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= 16'h0000;
            squash    <= 1'b0;
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
        end else begin
            state     <= state_nx;
            pc        <= pc_nx;
            imem_req  <= imem_req_nx;
            imem_addr <= imem_addr_nx;
            squash    <= squash_nx;
            count     <= count_nx;
            rd_ptr    <= rd_ptr_nx;
            wr_ptr    <= wr_ptr_nx;
        end
    end

    // Buffer storage needs no reset: reads are masked while empty
    always_ff @(posedge clock) begin
        if (push_c) mem[wr_ptr] <= push_data_c;
    end

endmodule

// File: tb/tb_fetch.sv
// Scoreboard bench for fetch: acked words are queued and compared as decode pops them.
module tb_fetch;

`ifdef FETCH_PREFETCH_BUF_EN
    localparam int unsigned DEPTH = 2;
`else
    localparam int unsigned DEPTH = 1;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        enable_fetch, br_taken, imem_ack, enable_decode;
    logic [15:0] taddr, imem_rdata;
    logic        imem_req, instr_valid;
    logic [15:0] imem_addr, instr_dout, npc_out, pc;

    logic        ef2, ack2;
    logic [15:0] rdata2;
    logic        req2, valid2;
    logic [15:0] addr2, dout2, npc2, pc2;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] sb[$];
    logic        auto_ack;
    logic [15:0] next_pc_exp;

    always #5 clock = ~clock;

    fetch u_dut (
        .clock(clock), .reset(reset), .enable_fetch(enable_fetch), .br_taken(br_taken),
        .taddr(taddr), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr_dout(instr_dout),
        .npc_out(npc_out), .enable_decode(enable_decode), .pc(pc)
    );

    fetch #(.RESET_PC(16'hFFFF)) u_dut_wrap (
        .clock(clock), .reset(reset), .enable_fetch(ef2), .br_taken(1'b0),
        .taddr(16'h0000), .imem_req(req2), .imem_addr(addr2), .imem_ack(ack2),
        .imem_rdata(rdata2), .instr_valid(valid2), .instr_dout(dout2),
        .npc_out(npc2), .enable_decode(1'b0), .pc(pc2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] addr);
        return addr + 16'h1234 - 16'h3000;
    endfunction

    // Decode pops are checked just before the edge that consumes them
    task automatic sb_check();
        logic [31:0] exp;
        if (instr_valid && enable_decode && !br_taken) begin
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                check("pop_word", {instr_dout, npc_out}, exp);
            end
        end
    endtask

    // Memory model: acks one cycle after a request is seen
    task automatic respond();
        if (auto_ack) begin
            if (imem_req && !imem_ack) begin
                imem_ack    = 1'b1;
                imem_rdata  = mem_word(imem_addr);
                sb.push_back({imem_rdata, imem_addr + 16'd1});
                next_pc_exp = imem_addr + 16'd1;
            end else begin
                imem_ack = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(negedge clock);
        sb_check();
        @(posedge clock);
        #1;
        respond();
    endtask

    initial begin
        logic        got;
        logic [15:0] first_addr;

        reset = 1'b0; enable_fetch = 1'b0; br_taken = 1'b0; taddr = 16'h0000;
        imem_ack = 1'b0; imem_rdata = 16'h0000; enable_decode = 1'b0;
        ef2 = 1'b0; ack2 = 1'b0; rdata2 = 16'h0000;
        auto_ack = 1'b0; next_pc_exp = 16'h3000; first_addr = 16'h0000;
        tick(); tick();

        check("rst_req",   32'(imem_req),    32'd0);
        check("rst_addr",  32'(imem_addr),   32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_dout",  32'(instr_dout),  32'd0);
        check("rst_npc",   32'(npc_out),     32'd0);
        check("rst_pc",    32'(pc),          32'h3000);

        // First fetch after reset release
        reset = 1'b1; enable_fetch = 1'b1; auto_ack = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !instr_valid; i++) begin
            tick();
            if (imem_req && !got) begin
                got = 1'b1;
                first_addr = imem_addr;
            end
        end
        check("first_valid", 32'(instr_valid), 32'd1);
        check("first_addr",  32'(first_addr),  32'h3000);
        check("first_dout",  32'(instr_dout),  32'h1234);
        check("first_npc",   32'(npc_out),     32'h3001);
        check("first_pc",    32'(pc),          32'h3001);

        // Stalled decode: buffer fills to DEPTH and fetching stops
        for (int i = 0; i < 6; i++) tick();
        check("stall_req",   32'(imem_req),    32'd0);
        check("stall_valid", 32'(instr_valid), 32'd1);
        check("stall_dout",  32'(instr_dout),  32'h1234);
        check("stall_npc",   32'(npc_out),     32'h3001);
        check("stall_pc",    32'(pc),          32'h3000 + DEPTH);

        // Random decode stalls with continuous fetch
        for (int i = 0; i < 30; i++) begin
            enable_decode = 1'($urandom_range(0, 1));
            tick();
        end

        // Drain
        enable_fetch = 1'b0; enable_decode = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!imem_req && !imem_ack && !instr_valid) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        check("drain_done", 32'(got), 32'd1);
        check("drain_sb",   32'(sb.size()), 32'd0);
        check("drain_pc",   32'(pc), 32'(next_pc_exp));

        // Redirect while a request is pending: old data squashed
        auto_ack = 1'b0; imem_ack = 1'b0; enable_fetch = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (imem_req) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        check("br_req_seen", 32'(got), 32'd1);
        check("br_old_addr", 32'(imem_addr), 32'(next_pc_exp));
        br_taken = 1'b1; taddr = 16'h4000; sb.delete();
        tick();
        br_taken = 1'b0;
        check("br_hold_req",  32'(imem_req),  32'd1);
        check("br_hold_addr", 32'(imem_addr), 32'(next_pc_exp));
        tick();
        check("br_hold_req2", 32'(imem_req), 32'd1);
        imem_ack = 1'b1; imem_rdata = 16'hDEAD;
        tick();
        imem_ack = 1'b0; enable_decode = 1'b0;
        check("squash_valid", 32'(instr_valid), 32'd0);
        check("squash_pc",    32'(pc),          32'h4000);
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (imem_req) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        check("tgt_req_seen", 32'(got), 32'd1);
        check("tgt_addr", 32'(imem_addr), 32'h4000);
        imem_ack = 1'b1; imem_rdata = 16'hBEEF;
        sb.push_back({16'hBEEF, 16'h4001});
        tick();
        imem_ack = 1'b0;
        check("tgt_valid", 32'(instr_valid), 32'd1);
        check("tgt_dout",  32'(instr_dout),  32'hBEEF);
        check("tgt_npc",   32'(npc_out),     32'h4001);
        check("tgt_pc",    32'(pc),          32'h4001);

        // Redirect coincident with ack (and a pop, if anything is buffered)
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (imem_req) begin
                got = 1'b1;
                break;
            end
            if (i >= 3) enable_decode = 1'b1;
            tick();
        end
        check("co_req_seen", 32'(got), 32'd1);
        check("co_addr", 32'(imem_addr), 32'h4001);
        enable_decode = 1'b1; imem_ack = 1'b1; imem_rdata = 16'hCAFE;
        br_taken = 1'b1; taddr = 16'h5000; sb.delete();
        tick();
        imem_ack = 1'b0; br_taken = 1'b0;
        check("co_valid", 32'(instr_valid), 32'd0);
        check("co_pc",    32'(pc),          32'h5000);
        check("co_req",   32'(imem_req),    32'd0);

        // Reset in the middle of a request, then a stray late ack
        tick();
        check("mid_req",  32'(imem_req),  32'd1);
        check("mid_addr", 32'(imem_addr), 32'h5000);
        reset = 1'b0;
        tick();
        reset = 1'b1; enable_fetch = 1'b0;
        check("mrst_req",   32'(imem_req),    32'd0);
        check("mrst_addr",  32'(imem_addr),   32'd0);
        check("mrst_pc",    32'(pc),          32'h3000);
        check("mrst_valid", 32'(instr_valid), 32'd0);
        check("mrst_dout",  32'(instr_dout),  32'd0);
        check("mrst_npc",   32'(npc_out),     32'd0);
        imem_ack = 1'b1; imem_rdata = 16'h1111;
        tick();
        imem_ack = 1'b0;
        check("late_valid", 32'(instr_valid), 32'd0);
        check("late_pc",    32'(pc),          32'h3000);
        check("late_req",   32'(imem_req),    32'd0);
        enable_fetch = 1'b1;
        tick();
        check("restart_req",  32'(imem_req),  32'd1);
        check("restart_addr", 32'(imem_addr), 32'h3000);

        // Address wrap at the top of memory
        ef2 = 1'b1;
        tick();
        check("wrap_req",  32'(req2),  32'd1);
        check("wrap_addr", 32'(addr2), 32'hFFFF);
        ack2 = 1'b1; rdata2 = 16'h7777;
        tick();
        ack2 = 1'b0; ef2 = 1'b0;
        check("wrap_valid", 32'(valid2), 32'd1);
        check("wrap_dout",  32'(dout2),  32'h7777);
        check("wrap_npc",   32'(npc2),   32'h0000);
        check("wrap_pc",    32'(pc2),    32'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
